// File: rtl/alu_share_arb.sv
// Round-robin sequencer that time-shares one combinational alu among NREQ requesters.
// Grant registers the operands, the alu result is captured a cycle later and returned on one channel.
module alu_share_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int unsigned DW   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [4*NREQ-1:0]  req_ctrl,
  input  logic [DW*NREQ-1:0] req_op_a,
  input  logic [DW*NREQ-1:0] req_op_b,
  output logic [3:0]         alu_ctrl,
  output logic [DW-1:0]      op_A,
  output logic [DW-1:0]      op_B,
  input  logic [DW-1:0]      alu_o,
  input  logic               br_mark,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_br,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic             grant_en;
  logic             gnt_any;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   nxt_ptr;
  logic [3:0]       sel_ctrl;
  logic [DW-1:0]    sel_a;
  logic [DW-1:0]    sel_b;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any    = 1'b1;
        gnt_id     = cand;
        gnt[cand]  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ctrl = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_ctrl = req_ctrl[4*i +: 4];
        sel_a    = req_op_a[DW*i +: DW];
        sel_b    = req_op_b[DW*i +: DW];
      end
    end
  end

  assign nxt_ptr   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  // Arbitration is open in IDLE, and in RESP only during the cycle the response completes.
  assign grant_en  = rstn && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
  assign req_ready = grant_en ? gnt : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      alu_ctrl  <= '0;
      op_A      <= '0;
      op_B      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_br    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            alu_ctrl <= sel_ctrl;
            op_A     <= sel_a;
            op_B     <= sel_b;
            rsp_id   <= gnt_id;
            rr_ptr_q <= nxt_ptr;
            busy     <= 1'b1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_data  <= alu_o;
          rsp_br    <= br_mark;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (gnt_any) begin
              alu_ctrl <= sel_ctrl;
              op_A     <= sel_a;
              op_B     <= sel_b;
              rsp_id   <= gnt_id;
              rr_ptr_q <= nxt_ptr;
              state_q  <= StExec;
            end else begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with three requesters and a small behavioural alu.
module tb_alu_share_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned IDW  = 2;
  localparam int unsigned DW   = 32;

  localparam logic [3:0] C_ADD   = 4'd0;
  localparam logic [3:0] C_SUB   = 4'd1;
  localparam logic [3:0] C_SLT   = 4'd2;
  localparam logic [3:0] C_NOTEQ = 4'd3;
  localparam logic [3:0] C_JUMP  = 4'd4;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_ctrl;
  logic [DW*NREQ-1:0] req_op_a;
  logic [DW*NREQ-1:0] req_op_b;
  logic [3:0]         alu_ctrl;
  logic [DW-1:0]      op_A;
  logic [DW-1:0]      op_B;
  logic [DW-1:0]      alu_o;
  logic               br_mark;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_br;
  logic               busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_op_a  (req_op_a),
    .req_op_b  (req_op_b),
    .alu_ctrl  (alu_ctrl),
    .op_A      (op_A),
    .op_B      (op_B),
    .alu_o     (alu_o),
    .br_mark   (br_mark),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_br    (rsp_br),
    .busy      (busy)
  );

  // Stand-in alu driven from the DUT's registered drive outputs.
  always_comb begin
    alu_o   = '0;
    br_mark = 1'b0;
    case (alu_ctrl)
      C_ADD:   alu_o = op_A + op_B;
      C_SUB:   begin alu_o = op_A - op_B; br_mark = (op_A == op_B); end
      C_SLT:   begin alu_o = {31'd0, $signed(op_A) < $signed(op_B)}; br_mark = alu_o[0]; end
      C_NOTEQ: br_mark = (op_A != op_B);
      C_JUMP:  begin alu_o = op_A + op_B; br_mark = 1'b1; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    req_ctrl[4*id +: 4]  = c;
    req_op_a[32*id +: 32] = a;
    req_op_b[32*id +: 32] = b;
  endtask

  // One isolated operation from requester id, starting and ending in IDLE.
  task automatic do_op(input string tag, input int id, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_d, input logic exp_br);
    set_req(id, c, a, b);
    req_valid = 3'b000;
    req_valid[id] = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(3'b001 << id));
    tick();
    req_valid = '0;
    tick();
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    chk({tag, "_data"}, 64'(rsp_data), 64'(exp_d));
    chk({tag, "_br"}, 64'(rsp_br), 64'(exp_br));
    tick();
    chk({tag, "_done"}, 64'(rsp_valid), 64'd0);
  endtask

  int exp_seq [4] = '{1, 0, 1, 0};
  logic [31:0] exp_dat [4] = '{32'd30, 32'd3, 32'd30, 32'd3};

  initial begin
    rstn      = 1'b0;
    req_valid = 3'b111;
    req_ctrl  = '0;
    req_op_a  = '1;
    req_op_b  = '1;
    rsp_ready = 1'b0;

    // Reset with everyone requesting
    repeat (3) tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_opa", 64'(op_A), 64'd0);
    chk("rst_opb", 64'(op_B), 64'd0);
    chk("rst_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_rsp", {rsp_data, 29'd0, rsp_br, rsp_id}, 64'd0);

    // Single op with response backpressure
    req_valid = '0;
    rstn = 1'b1;
    tick();
    set_req(0, C_ADD, 32'd5, 32'd7);
    req_valid = 3'b001;
    #1;
    chk("single_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    chk("single_exec_busy", 64'(busy), 64'd1);
    chk("single_exec_valid", 64'(rsp_valid), 64'd0);
    chk("single_opa", 64'(op_A), 64'd5);
    chk("single_opb", 64'(op_B), 64'd7);
    tick();
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_data", 64'(rsp_data), 64'd12);
    chk("single_br", 64'(rsp_br), 64'd0);
    repeat (4) begin
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_id", 64'(rsp_id), 64'd0);
      chk("hold_data", 64'(rsp_data), 64'd12);
    end
    rsp_ready = 1'b1;
    tick();
    chk("single_release", 64'(rsp_valid), 64'd0);
    chk("single_idle_busy", 64'(busy), 64'd0);

    // Fairness: rr_ptr is now 1, so grants run 1,0,1,0 with no idle cycle between ops
    set_req(0, C_ADD, 32'd1, 32'd2);
    set_req(1, C_ADD, 32'd10, 32'd20);
    req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fair_grant", 64'(req_ready), 64'(3'b001 << exp_seq[i]));
      tick();
      chk("fair_exec", 64'({busy, rsp_valid}), 64'b10);
      tick();
      chk("fair_valid", 64'(rsp_valid), 64'd1);
      chk("fair_id", 64'(rsp_id), 64'(exp_seq[i]));
      chk("fair_data", 64'(rsp_data), 64'(exp_dat[i]));
    end
    req_valid = '0;
    tick();
    chk("fair_idle", 64'(busy), 64'd0);

    // Branch flag cases on requester 1
    do_op("sub_eq", 1, C_SUB, 32'd9, 32'd9, 32'd0, 1'b1);
    do_op("noteq", 1, C_NOTEQ, 32'd3, 32'd4, 32'd0, 1'b1);
    do_op("slt", 1, C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
    do_op("jump", 1, C_JUMP, 32'h100, 32'd4, 32'h104, 1'b1);

    // Wrap: rr_ptr is 2, req0 and req2 pending
    set_req(0, C_ADD, 32'd1, 32'd1);
    set_req(2, C_ADD, 32'd2, 32'd2);
    req_valid = 3'b101;
    #1;
    chk("wrap_grant2", 64'(req_ready), 64'b100);
    tick();
    req_valid = 3'b001;
    tick();
    chk("wrap_id2", 64'(rsp_id), 64'd2);
    chk("wrap_data2", 64'(rsp_data), 64'd4);
    #1;
    chk("wrap_grant0", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    tick();
    chk("wrap_id0", 64'(rsp_id), 64'd0);
    chk("wrap_data0", 64'(rsp_data), 64'd2);
    tick();

    // Reset while in EXEC drops the operation
    set_req(1, C_ADD, 32'd3, 32'd3);
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    chk("midrst_exec", 64'(busy), 64'd1);
    rstn = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_opa", 64'(op_A), 64'd0);
    rstn = 1'b1;
    repeat (3) begin
      tick();
      chk("midrst_novalid", 64'(rsp_valid), 64'd0);
    end
    do_op("after_rst", 0, C_ADD, 32'd8, 32'd9, 32'd17, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
